// File: rtl/pipe_exe_stage.sv
// EXE stage: single-cycle ALU plus an iterative radix-2 multiply/divide unit that stalls upstream.
// Optional signed ADD/SUB overflow detection and write suppression: define PIPE_EXE_OVF_EN.
module pipe_exe_stage #(
  parameter logic [4:0]  LINK_REG    = 5'd31,
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ebubble,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic        ejal,
  input  logic [3:0]  ealuc,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  input  logic [31:0] esa,
  input  logic [31:0] epc4,
  input  logic [4:0]  ern0,
  output logic [31:0] ealu,
  output logic [31:0] ebdata,
  output logic [4:0]  ern,
  output logic        xwreg,
  output logic        xm2reg,
  output logic        xwmem,
  output logic        estall,
  output logic        eoverflow
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_st_e;

  mdu_st_e     state_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_q;     // multiplicand or divisor
  logic [63:0] acc_q;   // {hi,lo} product or {remainder,quotient}
  logic        div_q;

  logic [31:0] opa, opb, add_r, sub_r, alu_r;
  logic        mdu_go, ovf_kill;

  assign opa    = eshift  ? esa  : ea;
  assign opb    = ealuimm ? eimm : eb;
  assign add_r  = opa + opb;
  assign sub_r  = opa - opb;
  assign mdu_go = (ealuc[3:2] == 2'b10) & ~ebubble & ~ejal;

  // One radix-2 step: shift-add multiply or restoring divide
  logic [32:0] mul_sum;
  logic [32:0] div_rem_sh;
  logic [31:0] div_sub;
  logic        div_ok;
  logic [63:0] acc_d;

  assign mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  assign div_rem_sh = acc_q[63:31];
  assign div_ok     = (div_rem_sh >= {1'b0, a_q});
  assign div_sub    = div_rem_sh[31:0] - a_q;

  always_comb begin
    acc_d = {mul_sum, acc_q[31:1]};
    if (div_q) begin
      if (div_ok) acc_d = {div_sub, acc_q[30:0], 1'b1};
      else        acc_d = {div_rem_sh[31:0], acc_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mdu_go) begin
          state_q <= BUSY;
          cnt_q   <= '0;
          div_q   <= ealuc[1];
          a_q     <= ealuc[1] ? opb : opa;
          acc_q   <= {32'd0, (ealuc[1] ? opa : opb)};
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset must drop the stall even while a start-able MDU op sits on the inputs
  assign estall = resetn & ((state_q == BUSY) | ((state_q == IDLE) & mdu_go));

  always_comb begin
    alu_r = '0;
    case (ealuc)
      4'b0000: alu_r = add_r;
      4'b0100: alu_r = sub_r;
      4'b0001: alu_r = opa & opb;
      4'b0101: alu_r = opa | opb;
      4'b0010: alu_r = opa ^ opb;
      4'b0110: alu_r = {opb[15:0], 16'd0};
      4'b0011: alu_r = opb << opa[4:0];
      4'b0111: alu_r = opb >> opa[4:0];
      4'b1111: alu_r = $signed(opb) >>> opa[4:0];
      4'b1000, 4'b1010: alu_r = acc_q[31:0];
      4'b1001, 4'b1011: alu_r = acc_q[63:32];
      default: alu_r = '0;
    endcase
  end

  assign ealu   = ejal ? (epc4 + LINK_OFFSET) : alu_r;
  assign ern    = ejal ? LINK_REG : ern0;
  assign ebdata = eb;

`ifdef PIPE_EXE_OVF_EN
  logic add_ovf, sub_ovf;
  assign add_ovf  = (opa[31] == opb[31]) & (add_r[31] != opa[31]);
  assign sub_ovf  = (opa[31] != opb[31]) & (sub_r[31] != opa[31]);
  assign ovf_kill = resetn & ~ebubble &
                    (((ealuc == 4'b0000) & add_ovf) | ((ealuc == 4'b0100) & sub_ovf));
  assign eoverflow = ovf_kill;
`else
  assign ovf_kill  = 1'b0;
  assign eoverflow = 1'b0;
`endif

  assign xwreg  = ewreg  & ~ebubble & ~estall & ~ovf_kill;
  assign xwmem  = ewmem  & ~ebubble & ~estall & ~ovf_kill;
  assign xm2reg = em2reg & ~ebubble & ~estall;

endmodule
